// File: rtl/dta_pkg.sv
// Shared defaults and helpers for the dest-tag-append return tracker.
package dta_pkg;
  localparam int ADDRESS_WIDTH    = 4;
  localparam int VC_ADDRESS_WIDTH = 1;
  localparam int TAG_WIDTH        = 8;

  typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_e;

  // Width of one recorded {dst, vc, tag} entry.
  function automatic int dta_ret_info_width(int aw = ADDRESS_WIDTH,
                                            int vw = VC_ADDRESS_WIDTH,
                                            int tw = TAG_WIDTH);
    return aw + vw + tw;
  endfunction
endpackage

// File: rtl/dta_return_tracker_if.sv
// Request/response bus of the return tracker; slave = tracker side.
interface dta_return_tracker_if #(
  parameter int WIDTH_DATA       = 12,
  parameter int ADDRESS_WIDTH    = dta_pkg::ADDRESS_WIDTH,
  parameter int VC_ADDRESS_WIDTH = dta_pkg::VC_ADDRESS_WIDTH,
  parameter int TAG_WIDTH        = dta_pkg::TAG_WIDTH,
  parameter int DEPTH            = 8
);
  logic [WIDTH_DATA-1:0]       req_data_in;
  logic [ADDRESS_WIDTH-1:0]    req_dst_in;
  logic [VC_ADDRESS_WIDTH-1:0] req_vc_in;
  logic [TAG_WIDTH-1:0]        req_tag_in;
  logic                        req_valid_in;
  logic                        req_ready_out;
  logic [WIDTH_DATA-1:0]       req_data_out;
  logic                        req_valid_out;
  logic                        req_ready_in;
  logic [WIDTH_DATA-1:0]       rsp_data_in;
  logic                        rsp_valid_in;
  logic                        rsp_ready_out;
  logic [WIDTH_DATA-1:0]       rsp_data_out;
  logic [ADDRESS_WIDTH-1:0]    rsp_dst_out;
  logic [VC_ADDRESS_WIDTH-1:0] rsp_vc_out;
  logic [TAG_WIDTH-1:0]        rsp_tag_out;
  logic                        rsp_valid_out;
  logic                        rsp_ready_in;
  logic [$clog2(DEPTH+1)-1:0]  outstanding_out;
  logic                        err_out;

  modport slave (
    input  req_data_in, req_dst_in, req_vc_in, req_tag_in, req_valid_in, req_ready_in,
           rsp_data_in, rsp_valid_in, rsp_ready_in,
    output req_ready_out, req_data_out, req_valid_out, rsp_ready_out, rsp_data_out,
           rsp_dst_out, rsp_vc_out, rsp_tag_out, rsp_valid_out, outstanding_out, err_out
  );

  modport master (
    output req_data_in, req_dst_in, req_vc_in, req_tag_in, req_valid_in, req_ready_in,
           rsp_data_in, rsp_valid_in, rsp_ready_in,
    input  req_ready_out, req_data_out, req_valid_out, rsp_ready_out, rsp_data_out,
           rsp_dst_out, rsp_vc_out, rsp_tag_out, rsp_valid_out, outstanding_out, err_out
  );
endinterface

// File: rtl/dta_ret_fifo.sv
// Return-info FIFO: head is read combinationally; caller never pushes when full or pops when empty.
module dta_ret_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/dta_return_tracker.sv
// Records return dst/vc/tag per request and re-attaches them, in order, to responses.
// Optional sticky orphan-response error: define DTA_RETURN_TRACKER_ERR_EN.
module dta_return_tracker #(
  parameter int WIDTH_DATA       = 12,
  parameter int ADDRESS_WIDTH    = dta_pkg::ADDRESS_WIDTH,
  parameter int VC_ADDRESS_WIDTH = dta_pkg::VC_ADDRESS_WIDTH,
  parameter int TAG_WIDTH        = dta_pkg::TAG_WIDTH,
  parameter int DEPTH            = 8
) (
  input logic                clk,
  input logic                rst,
  dta_return_tracker_if.slave bus
);
  import dta_pkg::*;

  localparam int INFO_W = dta_ret_info_width(ADDRESS_WIDTH, VC_ADDRESS_WIDTH, TAG_WIDTH);
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              w_full, w_empty, w_push, w_pop;
  logic [INFO_W-1:0] w_head;
  logic [CNT_W-1:0]  w_count;
  out_state_e        r_state, w_state_nxt;

  logic [WIDTH_DATA-1:0]       r_data;
  logic [ADDRESS_WIDTH-1:0]    r_dst;
  logic [VC_ADDRESS_WIDTH-1:0] r_vc;
  logic [TAG_WIDTH-1:0]        r_tag;

  // Request side gates only on full, so no response-to-request combinational path exists.
  assign bus.req_data_out  = bus.req_data_in;
  assign bus.req_valid_out = bus.req_valid_in & ~w_full;
  assign bus.req_ready_out = bus.req_ready_in & ~w_full;
  assign w_push            = bus.req_valid_in & bus.req_ready_out;

  assign bus.rsp_ready_out = ~w_empty & ((r_state == OUT_EMPTY) | bus.rsp_ready_in);
  assign w_pop             = bus.rsp_valid_in & bus.rsp_ready_out;

  dta_ret_fifo #(.W(INFO_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({bus.req_dst_in, bus.req_vc_in, bus.req_tag_in}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.outstanding_out = w_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      OUT_EMPTY: if (w_pop) w_state_nxt = OUT_FULL;
      OUT_FULL:  if (!w_pop && bus.rsp_ready_in) w_state_nxt = OUT_EMPTY;
      default:   w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OUT_EMPTY;
      r_data  <= '0;
      r_dst   <= '0;
      r_vc    <= '0;
      r_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_data <= bus.rsp_data_in;
        r_dst  <= w_head[INFO_W-1 -: ADDRESS_WIDTH];
        r_vc   <= w_head[TAG_WIDTH +: VC_ADDRESS_WIDTH];
        r_tag  <= w_head[TAG_WIDTH-1:0];
      end
    end
  end

  assign bus.rsp_valid_out = (r_state == OUT_FULL);
  assign bus.rsp_data_out  = r_data;
  assign bus.rsp_dst_out   = r_dst;
  assign bus.rsp_vc_out    = r_vc;
  assign bus.rsp_tag_out   = r_tag;

`ifdef DTA_RETURN_TRACKER_ERR_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_err <= 1'b0;
    else if (bus.rsp_valid_in && w_empty) r_err <= 1'b1;
  end
  assign bus.err_out = r_err;
`else
  assign bus.err_out = 1'b0;
`endif
endmodule

// File: tb/tb_dta_return_tracker.sv
// Directed + random bench for dta_return_tracker against a queue-based reference model.
module tb_dta_return_tracker;
  localparam int WD = 12, AW = 4, VW = 1, TW = 8, DEPTH = 8;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic [VW-1:0] vc;
    logic [TW-1:0] tag;
  } info_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dta_return_tracker_if #(.WIDTH_DATA(WD), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW),
                          .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus ();

  dta_return_tracker #(.WIDTH_DATA(WD), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW),
                       .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of outstanding return info plus the expected output slot.
  info_t         q[$];
  logic          m_ov;
  logic [WD-1:0] m_data;
  info_t         m_info;
  logic          m_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_data = '0; m_info = '0; m_err = 1'b0;
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check registered state.
  task automatic tick(input logic rv, input logic [WD-1:0] rd, input logic [AW-1:0] dst,
                      input logic [VW-1:0] vc, input logic [TW-1:0] tag, input logic rrdy,
                      input logic sv, input logic [WD-1:0] sd, input logic srdy);
    logic full, e_rrdy, e_srdy, push, pop;
    info_t hd;
    bus.req_valid_in = rv; bus.req_data_in = rd; bus.req_dst_in = dst;
    bus.req_vc_in = vc; bus.req_tag_in = tag; bus.req_ready_in = rrdy;
    bus.rsp_valid_in = sv; bus.rsp_data_in = sd; bus.rsp_ready_in = srdy;
    #1;
    full   = (q.size() == DEPTH);
    e_rrdy = rrdy && !full;
    e_srdy = (q.size() != 0) && (!m_ov || srdy);
    chk("req_data_out",  32'(bus.req_data_out),  32'(rd));
    chk("req_valid_out", 32'(bus.req_valid_out), 32'(rv && !full));
    chk("req_ready_out", 32'(bus.req_ready_out), 32'(e_rrdy));
    chk("rsp_ready_out", 32'(bus.rsp_ready_out), 32'(e_srdy));
    push = rv && e_rrdy;
    pop  = sv && e_srdy;
`ifdef DTA_RETURN_TRACKER_ERR_EN
    if (sv && q.size() == 0) m_err = 1'b1;
`endif
    @(posedge clk);
    #1;
    if (pop) begin
      hd = q.pop_front();
      m_ov = 1'b1; m_data = sd; m_info = hd;
    end else if (srdy) begin
      m_ov = 1'b0;
    end
    if (push) q.push_back('{dst: dst, vc: vc, tag: tag});
    chk("rsp_valid_out",   32'(bus.rsp_valid_out),   32'(m_ov));
    chk("outstanding_out", 32'(bus.outstanding_out), 32'(q.size()));
    chk("err_out",         32'(bus.err_out),         32'(m_err));
    if (m_ov) begin
      chk("rsp_data_out", 32'(bus.rsp_data_out), 32'(m_data));
      chk("rsp_dst_out",  32'(bus.rsp_dst_out),  32'(m_info.dst));
      chk("rsp_vc_out",   32'(bus.rsp_vc_out),   32'(m_info.vc));
      chk("rsp_tag_out",  32'(bus.rsp_tag_out),  32'(m_info.tag));
    end
  endtask

  task automatic idle(input logic srdy);
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, '0, srdy);
  endtask

  task automatic push_req(input logic [TW-1:0] tag);
    tick(1'b1, WD'($urandom), AW'($urandom), VW'($urandom), tag, 1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    model_reset();
    bus.req_valid_in = 0; bus.req_data_in = 0; bus.req_dst_in = 0; bus.req_vc_in = 0;
    bus.req_tag_in = 0; bus.req_ready_in = 1; bus.rsp_valid_in = 0; bus.rsp_data_in = 0;
    bus.rsp_ready_in = 0;

    // Reset state
    #2;
    chk("rst_req_ready_hi", 32'(bus.req_ready_out), 32'd1);
    chk("rst_rsp_ready",    32'(bus.rsp_ready_out), 32'd0);
    chk("rst_rsp_valid",    32'(bus.rsp_valid_out), 32'd0);
    chk("rst_outstanding",  32'(bus.outstanding_out), 32'd0);
    chk("rst_rsp_data",     32'(bus.rsp_data_out), 32'd0);
    chk("rst_rsp_dst",      32'(bus.rsp_dst_out), 32'd0);
    chk("rst_rsp_tag",      32'(bus.rsp_tag_out), 32'd0);
    chk("rst_err",          32'(bus.err_out), 32'd0);
    bus.req_ready_in = 0;
    #1;
    chk("rst_req_ready_lo", 32'(bus.req_ready_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request/response
    tick(1'b1, 12'h123, 4'd5, 1'b1, 8'h3C, 1'b1, 1'b0, '0, 1'b1);
    chk("single_cnt1", 32'(bus.outstanding_out), 32'd1);
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'hABC, 1'b1);
    chk("single_data", 32'(bus.rsp_data_out), 32'hABC);
    chk("single_dst",  32'(bus.rsp_dst_out),  32'd5);
    chk("single_vc",   32'(bus.rsp_vc_out),   32'd1);
    chk("single_tag",  32'(bus.rsp_tag_out),  32'h3C);
    chk("single_cnt0", 32'(bus.outstanding_out), 32'd0);
    idle(1'b1);

    // Fill to DEPTH, 9th blocked, drain in order
    for (int i = 0; i < DEPTH; i++) push_req(TW'(i));
    chk("fill_cnt", 32'(bus.outstanding_out), 32'(DEPTH));
    push_req(8'hFF);
    chk("fill_cnt_blocked", 32'(bus.outstanding_out), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, WD'($urandom), 1'b1);
      chk("drain_tag", 32'(bus.rsp_tag_out), 32'(i));
    end
    idle(1'b1);

    // Streaming: push and pop every cycle
    push_req(8'h40);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, WD'($urandom), AW'(i), VW'(i), TW'(8'h41 + i), 1'b1, 1'b1, WD'(i), 1'b1);
      chk("stream_valid", 32'(bus.rsp_valid_out), 32'd1);
      chk("stream_cnt",   32'(bus.outstanding_out), 32'd1);
    end
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'h777, 1'b1);
    idle(1'b1);

    // Back-pressure: stall 3 cycles, then accept on the draining cycle
    push_req(8'h50); push_req(8'h51); push_req(8'h52);
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'h500, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'h501, 1'b0);
      chk("stall_tag", 32'(bus.rsp_tag_out), 32'h50);
    end
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'h501, 1'b1);
    chk("release_tag", 32'(bus.rsp_tag_out), 32'h51);
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'h502, 1'b1);
    idle(1'b1);

    // Orphan response while empty
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'hEEE, 1'b1);
    idle(1'b1);

    // Asynchronous reset with entries outstanding and a loaded output
    for (int i = 0; i < 5; i++) push_req(TW'(8'h60 + i));
    tick(1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 12'h600, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid",   32'(bus.rsp_valid_out), 32'd0);
    chk("arst_outstanding", 32'(bus.outstanding_out), 32'd0);
    chk("arst_rsp_data",    32'(bus.rsp_data_out), 32'd0);
    chk("arst_err",         32'(bus.err_out), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic rv, sv, srdy, rrdy;
      rv   = ($urandom_range(0, 3) != 0);
      sv   = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      srdy = ($urandom_range(0, 3) != 0);
      rrdy = ($urandom_range(0, 4) != 0);
      tick(rv, WD'($urandom), AW'($urandom), VW'($urandom), TW'($urandom), rrdy,
           sv, WD'($urandom), srdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dta_return_tracker.md
# dta_return_tracker

Return-address tracker that sits between the dest-tag-append depacketizer and the compute module it feeds, and between that module and the response packetizer. It records the return destination, VC and tag of every request delivered to the compute module, in arrival order. It re-attaches them, in the same order, to each response the module produces, so responses are routed back to the originating requester. It also throttles requests so that outstanding requests never exceed its table depth.

## Interface
Parameters:
- WIDTH_DATA, 12: request/response payload width
- ADDRESS_WIDTH, 4: NoC router address width
- VC_ADDRESS_WIDTH, 1: VC field width
- TAG_WIDTH, 8: return tag width
- DEPTH, 8: max outstanding requests; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_data_in  in  WIDTH_DATA  request payload from depacketizer
- req_dst_in  in  ADDRESS_WIDTH  return destination
- req_vc_in  in  VC_ADDRESS_WIDTH  return VC
- req_tag_in  in  TAG_WIDTH  return tag
- req_valid_in  in  1  request valid
- req_ready_out  out  1  request accepted
- req_data_out  out  WIDTH_DATA  payload to compute module
- req_valid_out  out  1  payload valid to module
- req_ready_in  in  1  module ready
- rsp_data_in  in  WIDTH_DATA  response payload from module
- rsp_valid_in  in  1  response valid
- rsp_ready_out  out  1  response accepted
- rsp_data_out  out  WIDTH_DATA  response to packetizer
- rsp_dst_out  out  ADDRESS_WIDTH  response destination (recorded return dest)
- rsp_vc_out  out  VC_ADDRESS_WIDTH  response VC
- rsp_tag_out  out  TAG_WIDTH  response tag
- rsp_valid_out  out  1  response valid to packetizer
- rsp_ready_in  in  1  packetizer ready
- outstanding_out  out  $clog2(DEPTH+1)  current table occupancy
- err_out  out  1  sticky protocol error (see Configuration)

## Operation
- Request path is combinational pass-through:
  - req_data_out = req_data_in.
  - req_valid_out = req_valid_in & ~full.
  - req_ready_out = req_ready_in & ~full.
- Push: when req_valid_in & req_ready_out, write {dst, vc, tag} to the table tail.
- Response path uses a one-entry output register with states OUT_EMPTY and OUT_FULL.
  - rsp_ready_out = ~empty & (OUT_EMPTY | rsp_ready_in).
  - On rsp_valid_in & rsp_ready_out: pop the table head, then load the output register with rsp_data_in plus the popped dst/vc/tag; state becomes OUT_FULL.
  - OUT_FULL → OUT_EMPTY when rsp_ready_in and no new load that cycle.
  - Load and drain in the same cycle keeps OUT_FULL with new contents.
- Count: incremented on push only, decremented on pop only, unchanged on simultaneous push and pop.
  - full = (count == DEPTH); empty = (count == 0).
  - outstanding_out = count.
- Boundaries:
  - Full blocks push even if a pop occurs the same cycle; there is no rsp→req combinational path.
  - Empty blocks pop even if a push occurs the same cycle; a response needs one cycle after its request's push.
  - Table pointers wrap modulo DEPTH.
  - Responses are assumed to come back in request order; the block does not reorder.

## Timing
- Reset values: count=0, pointers=0, OUT_EMPTY, rsp_valid_out=0, rsp_data/dst/vc/tag_out=0, err_out=0.
- Combinational outputs during reset: req_ready_out follows req_ready_in; rsp_ready_out=0.
- Request latency: 0 cycles.
- Response latency: 1 cycle (accept at edge N, rsp_valid_out high after edge N).
- Full throughput: one response per cycle with rsp_ready_in held high.
- Handshakes: rsp_*_out hold stable while rsp_valid_out & ~rsp_ready_in.
- Reset mid-operation: all outstanding entries are discarded and the output register is cleared.

## Configuration
- DTA_RETURN_TRACKER_ERR_EN defined:
  - err_out sets on any cycle with rsp_valid_in=1 and count=0, i.e. a response with no recorded request.
  - err_out is sticky until rst.
- DTA_RETURN_TRACKER_ERR_EN undefined: err_out is tied 0 and no error logic is built.

## Structure
- Package dta_pkg holds:
  - default widths (ADDRESS_WIDTH, VC_ADDRESS_WIDTH, TAG_WIDTH);
  - function dta_ret_info_width() returning ADDRESS_WIDTH+VC_ADDRESS_WIDTH+TAG_WIDTH.
- The metadata table is sub-module dta_ret_fifo: a synchronous FIFO of DEPTH entries with push, pop, full, empty and count. The top level holds the pass-through gating, the output register FSM and the error logic.

## Test plan
- Single request dst=5, vc=1, tag=0x3C, then response data=0xABC → next cycle rsp_valid_out=1 with data 0xABC, dst 5, vc 1, tag 0x3C; outstanding_out goes 0→1→0.
- Push 8 requests with tags 0..7 and no responses → req_ready_out=0 on the 9th attempt, outstanding_out=8; then 8 responses → tags emitted in order 0..7.
- Continuous streaming with rsp_ready_in=1 → one response per cycle; count is unchanged on cycles with simultaneous push and pop.
- rsp_ready_in held 0 for 3 cycles with a response loaded → outputs stable, rsp_ready_out=0; after release, the next response is accepted in the same cycle the register drains.
- rsp_valid_in=1 with count=0 → rsp_ready_out=0; err_out=1 with DTA_RETURN_TRACKER_ERR_EN, stays 0 without it.
- rst asserted with 4 outstanding and a loaded output → rsp_valid_out=0 and outstanding_out=0 immediately, without waiting for a clock edge.
